// File: rtl/servo_pkg.sv
// Shared definitions for the servo control blocks: state encoding and duty code format.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int          DUTY_W      = 8;
  localparam logic [7:0]  DUTY_CENTER = 8'd128;

endpackage

// File: rtl/servo_ramp_if.sv
// Target-position command channel: valid/ready handshake carrying an 8-bit duty code.
interface servo_ramp_if;
  import servo_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_pos;

  modport master (output cmd_valid, output cmd_pos, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);

endinterface

// File: rtl/servo_frame_tick.sv
// Free-running frame divider: one-cycle tick every CLK_HZ/CYC_HZ clocks.
module servo_frame_tick #(
  parameter int CLK_HZ = 25000000,
  parameter int CYC_HZ = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TERM = CLK_HZ / CYC_HZ;
  localparam int CW   = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TERM - 1));

  // Count clocks within a frame, wrapping on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// Servo duty ramp: accepts a target duty code and slews toward it by STEP per
// frame, then holds for HOLD_FRAMES frames (0 = forever) before releasing en.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int CYC_HZ      = 50,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst,
  servo_ramp_if.slave       cmd,
  output logic [DUTY_W-1:0] duty,
  output logic              en,
  output logic              busy,
  output logic              at_target
);

  localparam int                HW     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic signed [8:0] STEP_S = 9'(STEP);
  localparam logic [7:0]        STEP_8 = 8'(STEP);

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [HW-1:0]     hold_cnt;
  logic              ready;
  logic              tick;
  logic              accept;
  logic signed [8:0] diff;
  logic signed [8:0] mag;

  servo_frame_tick #(
    .CLK_HZ (CLK_HZ),
    .CYC_HZ (CYC_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid & ready;

  // Signed distance to target and its magnitude; 9 bits covers -255..255.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, duty});
    mag  = diff;
    if (diff < 0) begin
      mag = -diff;
    end
  end

  // Control FSM with registered outputs; acceptance takes priority over a
  // coincident tick so a new target never gets a step in its accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= DUTY_CENTER;
      target    <= DUTY_CENTER;
      en        <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      ready     <= 1'b0;
      hold_cnt  <= '0;
    end else if (accept) begin
      target   <= cmd.cmd_pos;
      en       <= 1'b1;
      hold_cnt <= '0;
      if (cmd.cmd_pos == duty) begin
        state     <= HOLD;
        busy      <= 1'b0;
        at_target <= 1'b1;
        ready     <= 1'b1;
      end else begin
        state     <= RAMP;
        busy      <= 1'b1;
        at_target <= 1'b0;
        ready     <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          ready     <= 1'b1;
          en        <= 1'b0;
          busy      <= 1'b0;
          at_target <= 1'b0;
        end
        RAMP: begin
          if (tick) begin
            if (mag <= STEP_S) begin
              duty      <= target;
              state     <= HOLD;
              busy      <= 1'b0;
              at_target <= 1'b1;
              ready     <= 1'b1;
              hold_cnt  <= '0;
            end else if (diff < 0) begin
              duty <= duty - STEP_8;
            end else begin
              duty <= duty + STEP_8;
            end
          end
        end
        HOLD: begin
          if (tick && (HOLD_FRAMES != 0)) begin
            if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
              state     <= IDLE;
              en        <= 1'b0;
              at_target <= 1'b0;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          en        <= 1'b0;
          busy      <= 1'b0;
          at_target <= 1'b0;
          ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp: 20 clocks per frame, two instances
// (STEP=4/HOLD_FRAMES=3 and STEP=100/HOLD_FRAMES=0) sharing clock and reset.
module tb_servo_ramp;
  import servo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ecnt;

  logic [7:0] duty_a, duty_b;
  logic       en_a, en_b, busy_a, busy_b, at_a, at_b;

  servo_ramp_if ifa ();
  servo_ramp_if ifb ();

  always #5 clk = ~clk;

  // Edges since reset release; a frame tick is applied on every 20th edge.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  servo_ramp #(.CLK_HZ(1000), .CYC_HZ(50), .STEP(4), .HOLD_FRAMES(3)) dut_a (
    .clk(clk), .rst(rst), .cmd(ifa), .duty(duty_a), .en(en_a), .busy(busy_a), .at_target(at_a)
  );

  servo_ramp #(.CLK_HZ(1000), .CYC_HZ(50), .STEP(100), .HOLD_FRAMES(0)) dut_b (
    .clk(clk), .rst(rst), .cmd(ifb), .duty(duty_b), .en(en_b), .busy(busy_b), .at_target(at_b)
  );

  task automatic next_tick();
    do @(negedge clk); while (ecnt % 20 != 0);
  endtask

  task automatic send_a(input logic [7:0] p);
    ifa.cmd_valid = 1'b1;
    ifa.cmd_pos   = p;
    @(negedge clk);
    ifa.cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    ifb.cmd_valid = 1'b1;
    ifb.cmd_pos   = p;
    @(negedge clk);
    ifb.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (duty_a !== 8'd128) begin fails++; $display("FAIL rst_duty: got %0d want 128", duty_a); end
    tests++; if ({en_a, busy_a, at_a} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {en_a, busy_a, at_a}); end
    tests++; if ({ifa.cmd_ready, ifb.cmd_ready} !== 2'b00) begin fails++; $display("FAIL rst_ready: got %b want 00", {ifa.cmd_ready, ifb.cmd_ready}); end
    rst = 1'b0;
    #1;
    tests++; if (ifa.cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", ifa.cmd_ready); end
    @(negedge clk);
    tests++; if (ifa.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b want 1", ifa.cmd_ready); end
  endtask

  task automatic test_ramp_up();
    send_a(8'd140);
    tests++; if ({busy_a, en_a, ifa.cmd_ready} !== 3'b110) begin fails++; $display("FAIL accept_flags: got %b want 110", {busy_a, en_a, ifa.cmd_ready}); end
    tests++; if (duty_a !== 8'd128) begin fails++; $display("FAIL accept_duty: got %0d want 128", duty_a); end
    repeat (10) @(negedge clk);
    tests++; if (duty_a !== 8'd128) begin fails++; $display("FAIL mid_frame_duty: got %0d want 128", duty_a); end
    next_tick();
    tests++; if (duty_a !== 8'd132) begin fails++; $display("FAIL ramp_t1: got %0d want 132", duty_a); end
    next_tick();
    tests++; if (duty_a !== 8'd136) begin fails++; $display("FAIL ramp_t2: got %0d want 136", duty_a); end
    next_tick();
    tests++; if (duty_a !== 8'd140) begin fails++; $display("FAIL ramp_t3: got %0d want 140", duty_a); end
    tests++; if ({at_a, busy_a, ifa.cmd_ready} !== 3'b101) begin fails++; $display("FAIL ramp_hold_flags: got %b want 101", {at_a, busy_a, ifa.cmd_ready}); end
  endtask

  task automatic test_hold_timeout();
    next_tick();
    next_tick();
    tests++; if ({en_a, at_a} !== 2'b11) begin fails++; $display("FAIL hold_2ticks: got %b want 11", {en_a, at_a}); end
    next_tick();
    tests++; if ({en_a, at_a, ifa.cmd_ready} !== 3'b001) begin fails++; $display("FAIL hold_timeout: got %b want 001", {en_a, at_a, ifa.cmd_ready}); end
    repeat (25) @(negedge clk);
    tests++; if (duty_a !== 8'd140 || en_a !== 1'b0) begin fails++; $display("FAIL idle_retain: got duty %0d en %b want 140 0", duty_a, en_a); end
  endtask

  task automatic test_same_pos();
    send_a(8'd140);
    tests++; if ({at_a, en_a, busy_a} !== 3'b110) begin fails++; $display("FAIL same_pos_flags: got %b want 110", {at_a, en_a, busy_a}); end
    tests++; if (duty_a !== 8'd140) begin fails++; $display("FAIL same_pos_duty: got %0d want 140", duty_a); end
  endtask

  task automatic test_ignore_in_ramp();
    send_a(8'd150);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b want 1", busy_a); end
    next_tick();
    ifa.cmd_valid = 1'b1;
    ifa.cmd_pos   = 8'd0;
    repeat (5) @(negedge clk);
    tests++; if (ifa.cmd_ready !== 1'b0 || duty_a !== 8'd144) begin fails++; $display("FAIL ramp_ignore: got ready %b duty %0d want 0 144", ifa.cmd_ready, duty_a); end
    ifa.cmd_valid = 1'b0;
    next_tick();
    tests++; if (duty_a !== 8'd148) begin fails++; $display("FAIL ramp_150_t2: got %0d want 148", duty_a); end
    next_tick();
    tests++; if (duty_a !== 8'd150 || at_a !== 1'b1) begin fails++; $display("FAIL ramp_150_final: got %0d at %b want 150 1", duty_a, at_a); end
  endtask

  task automatic test_hold_restart();
    next_tick();
    next_tick();
    send_a(8'd154);
    tests++; if ({busy_a, at_a} !== 2'b10) begin fails++; $display("FAIL hold_restart: got %b want 10", {busy_a, at_a}); end
    next_tick();
    tests++; if (duty_a !== 8'd154 || at_a !== 1'b1) begin fails++; $display("FAIL restart_reach: got %0d at %b want 154 1", duty_a, at_a); end
    next_tick();
    next_tick();
    tests++; if (en_a !== 1'b1) begin fails++; $display("FAIL hold_cnt_cleared: got en %b want 1", en_a); end
    next_tick();
    tests++; if (en_a !== 1'b0) begin fails++; $display("FAIL hold_restart_timeout: got en %b want 0", en_a); end
  endtask

  task automatic test_accept_on_tick();
    do @(negedge clk); while (ecnt % 20 != 19);
    send_a(8'd100);
    tests++; if (busy_a !== 1'b1 || duty_a !== 8'd154) begin fails++; $display("FAIL tick_accept: got busy %b duty %0d want 1 154", busy_a, duty_a); end
    repeat (10) @(negedge clk);
    tests++; if (duty_a !== 8'd154) begin fails++; $display("FAIL tick_accept_mid: got %0d want 154", duty_a); end
    next_tick();
    tests++; if (duty_a !== 8'd150) begin fails++; $display("FAIL tick_accept_step: got %0d want 150", duty_a); end
  endtask

  task automatic test_reset_mid_ramp();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (duty_a !== 8'd128 || en_a !== 1'b0) begin fails++; $display("FAIL async_rst: got duty %0d en %b want 128 0", duty_a, en_a); end
    tests++; if (busy_a !== 1'b0 || ifa.cmd_ready !== 1'b0) begin fails++; $display("FAIL async_rst_flags: got busy %b ready %b want 0 0", busy_a, ifa.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ifa.cmd_ready !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL post_rst: got ready %b busy %b want 1 0", ifa.cmd_ready, busy_a); end
    next_tick();
    next_tick();
    tests++; if (duty_a !== 8'd128 || en_a !== 1'b0) begin fails++; $display("FAIL no_pending: got duty %0d en %b want 128 0", duty_a, en_a); end
  endtask

  task automatic test_big_step();
    send_b(8'd140);
    next_tick();
    tests++; if (duty_b !== 8'd140 || at_b !== 1'b1) begin fails++; $display("FAIL big_up: got %0d at %b want 140 1", duty_b, at_b); end
    send_b(8'd0);
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL big_busy: got %b want 1", busy_b); end
    next_tick();
    tests++; if (duty_b !== 8'd40) begin fails++; $display("FAIL big_t1: got %0d want 40", duty_b); end
    next_tick();
    tests++; if (duty_b !== 8'd0 || at_b !== 1'b1 || busy_b !== 1'b0) begin fails++; $display("FAIL big_t2: got %0d at %b busy %b want 0 1 0", duty_b, at_b, busy_b); end
  endtask

  task automatic test_hold_forever();
    repeat (5) next_tick();
    tests++; if ({en_b, at_b} !== 2'b11 || duty_b !== 8'd0) begin fails++; $display("FAIL hold_forever: got en/at %b duty %0d want 11 0", {en_b, at_b}, duty_b); end
  endtask

  initial begin
    ifa.cmd_valid = 1'b0;
    ifa.cmd_pos   = 8'd0;
    ifb.cmd_valid = 1'b0;
    ifb.cmd_pos   = 8'd0;
    test_reset();
    test_ramp_up();
    test_hold_timeout();
    test_same_pos();
    test_ignore_in_ramp();
    test_hold_restart();
    test_accept_on_tick();
    test_reset_mid_ramp();
    test_big_step();
    test_hold_forever();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 25000000, giving the global clock frequency in Hz.
REQ-002 The module SHALL have parameter CYC_HZ, default 50, giving the servo frame rate in Hz.
REQ-003 The module SHALL have parameter STEP, default 4, giving the duty change applied per frame (legal range 1..255).
REQ-004 The module SHALL have parameter HOLD_FRAMES, default 50, giving the frames to hold at target before releasing en; 0 means hold forever.
REQ-005 The module SHALL have port clk, input, 1 bit: global clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port cmd_valid, input, 1 bit: a target position is offered.
REQ-008 The module SHALL have port cmd_ready, output, 1 bit: the block accepts a target this cycle.
REQ-009 The module SHALL have port cmd_pos, input, 8 bits: the target duty code.
REQ-010 The module SHALL have port duty, output, 8 bits: the current duty code driven to the downstream PDM generator.
REQ-011 The module SHALL have port en, output, 1 bit: the enable driven to the downstream PDM generator.
REQ-012 The module SHALL have port busy, output, 1 bit: the block is ramping.
REQ-013 The module SHALL have port at_target, output, 1 bit: duty equals the latched target and the block is in HOLD.

Function
REQ-014 The block SHALL generate a one-cycle frame tick every CLK_HZ/CYC_HZ clocks from a free-running counter that wraps at CLK_HZ/CYC_HZ-1.
REQ-015 The state machine SHALL have the states IDLE, RAMP and HOLD, and SHALL start in IDLE.
REQ-016 cmd_ready SHALL be 1 in IDLE and HOLD, and 0 in RAMP and during reset.
REQ-017 A command SHALL be accepted on cycle N when cmd_valid and cmd_ready are both 1; at N+1 the target is latched, en is 1, and the state is RAMP (or HOLD if cmd_pos equals duty).
REQ-018 cmd_valid held while cmd_ready is 0 SHALL be ignored and SHALL NOT be queued.
REQ-019 In RAMP, on each tick: if |target-duty| <= STEP, duty SHALL become target and the state SHALL go to HOLD; otherwise duty SHALL move STEP toward target.
REQ-020 Step arithmetic SHALL be 9-bit signed, and duty SHALL never wrap or overshoot the target.
REQ-021 duty SHALL change only on tick cycles (one step per frame), never mid-frame.
REQ-022 When acceptance and tick coincide in the same cycle, acceptance SHALL win and no step SHALL be applied in that cycle.
REQ-023 In HOLD, en SHALL stay 1 and the hold counter SHALL increment per tick; after HOLD_FRAMES ticks the state SHALL go to IDLE and en SHALL become 0.
REQ-024 With HOLD_FRAMES=0, HOLD SHALL never time out.
REQ-025 The hold counter SHALL be cleared on every HOLD entry, including a new command accepted in HOLD.
REQ-026 duty SHALL retain its value in IDLE, and en SHALL be 0 in IDLE.
REQ-027 busy SHALL equal (state==RAMP), and at_target SHALL equal (state==HOLD).

Reset
REQ-028 On asynchronous rst assertion: state SHALL be IDLE, duty SHALL be 8'd128, en, busy, at_target and cmd_ready SHALL be 0, and the frame and hold counters SHALL be 0.
REQ-029 Reset asserted mid-RAMP SHALL abort immediately, with no pending target retained.
REQ-030 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-031 The shared package servo_pkg SHALL contain the state enum (IDLE/RAMP/HOLD), DUTY_W=8 and DUTY_CENTER=8'd128.
REQ-032 The frame tick SHALL be a sub-module servo_frame_tick (parameters CLK_HZ, CYC_HZ; ports clk, rst, tick), reusable by other servo blocks.
REQ-033 The counter widths SHALL be $clog2 of their terminal counts.

Verification (bench uses CLK_HZ=1000, CYC_HZ=50, i.e. 20 clocks/frame)
REQ-034 Scenario: reset, then cmd_pos=140 with STEP=4 -> duty 128,132,136,140 on successive ticks; at_target after the 3rd tick.
REQ-035 Scenario: from duty=140, cmd_pos=0 with STEP=100 -> duty 40 then 0, with no underflow or wrap.
REQ-036 Scenario: cmd_pos equal to the current duty -> HOLD at N+1, en=1, duty unchanged.
REQ-037 Scenario: HOLD_FRAMES=3 -> en drops in the cycle after the 3rd tick in HOLD, and duty is retained in IDLE.
REQ-038 Scenario: cmd_valid during RAMP is ignored (cmd_ready=0); a new command accepted in HOLD restarts the ramp and clears the hold counter.
REQ-039 Scenario: acceptance on a tick cycle -> no step in that frame; rst pulse mid-RAMP -> duty=128 and en=0 asynchronously.
